// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for lock with bounded retries,
// qualifies lock over a stability window, then releases the CPU system reset.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       lock_fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, locked_s_q;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_n_q, sys_rst_n_d;
    logic            pll_ready_q, pll_ready_d;
    logic            lock_fail_q, lock_fail_d;
    logic [3:0]      retry_cnt_q, retry_cnt_d;
    logic [7:0]      loss_cnt_q, loss_cnt_d;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= locked;
            locked_s_q  <= sync1_q;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_ready_q <= pll_ready_d;
            lock_fail_q <= lock_fail_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        if (force_relock) begin
            state_d     = S_PLL_RST;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == CW'(RST_PULSE_CYCLES - 1)) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        if (retry_cnt_q < 4'(MAX_RETRIES)) begin
                            retry_cnt_d = retry_cnt_q + 4'd1;
                            state_d     = S_PLL_RST;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s_q) state_d = S_WAIT_LOCK;
                    else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!locked_s_q) begin
                        state_d     = S_PLL_RST;
                        retry_cnt_d = '0;
                        if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
                S_FAIL: state_d = S_FAIL;
                default: state_d = S_PLL_RST;
            endcase
        end
        // A forced restart clears the count even when already in PLL_RST; RUN/FAIL never count.
        if (force_relock || state_d != state_q || state_q == S_RUN || state_q == S_FAIL)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    // Outputs are decoded from the next state so they register on the transition edge.
    always_comb begin
        pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        pll_ready_d = (state_d == S_RUN);
        lock_fail_d = (state_d == S_FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_ready = pll_ready_q;
    assign lock_fail = lock_fail_q;
    assign retry_cnt = retry_cnt_q;
    assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/relock/reset traffic,
// every cycle compared against a deadline-based behavioural model.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;

    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_DEAD  = 4;

    logic       refclk = 1'b0;
    logic       drv_rst_n = 1'b0;
    logic       drv_locked = 1'b0;
    logic       drv_force = 1'b0;
    logic       pll_rst, sys_rst_n, pll_ready, lock_fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_phase, m_deadline, m_retry, m_loss;
    bit m_s1, m_s2;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES(RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk),
        .rst_n(drv_rst_n),
        .locked(drv_locked),
        .force_relock(drv_force),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .pll_ready(pll_ready),
        .lock_fail(lock_fail),
        .retry_cnt(retry_cnt),
        .loss_cnt(loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Each phase has a fixed lifetime; the deadline is the edge on which it expires.
    task automatic enter(input int p);
        m_phase = p;
        case (p)
            P_PULSE: m_deadline = cyc + RP;
            P_WAIT:  m_deadline = cyc + TO;
            P_STAB:  m_deadline = cyc + ST;
            default: m_deadline = -1;
        endcase
    endtask

    task automatic model_edge();
        bit ls;
        if (!drv_rst_n) begin
            m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
            enter(P_PULSE);
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = drv_locked;
        if (drv_force) begin
            m_retry = 0;
            enter(P_PULSE);
        end else begin
            case (m_phase)
                P_PULSE: if (cyc == m_deadline) enter(P_WAIT);
                P_WAIT: begin
                    if (ls) enter(P_STAB);
                    else if (cyc == m_deadline) begin
                        if (m_retry < MR) begin m_retry++; enter(P_PULSE); end
                        else enter(P_DEAD);
                    end
                end
                P_STAB: begin
                    if (!ls) enter(P_WAIT);
                    else if (cyc == m_deadline) enter(P_RUN);
                end
                P_RUN: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        m_retry = 0;
                        enter(P_PULSE);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("pll_rst",   pll_rst,   (m_phase == P_PULSE || m_phase == P_DEAD));
        check("sys_rst_n", sys_rst_n, (m_phase == P_RUN));
        check("pll_ready", pll_ready, (m_phase == P_RUN));
        check("lock_fail", lock_fail, (m_phase == P_DEAD));
        check("retry_cnt", retry_cnt, m_retry);
        check("loss_cnt",  loss_cnt,  m_loss);
    endtask

    task automatic tick();
        @(posedge refclk);
        cyc++;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_until_release(input int limit, output int edge_at);
        int n = 0;
        while (sys_rst_n !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("release_within_bound", sys_rst_n, 1);
        edge_at = cyc;
    endtask

    task automatic wait_phase(input int p, input int limit);
        int n = 0;
        while (m_phase != p && n < limit) begin
            tick();
            n++;
        end
        check("phase_within_bound", m_phase, p);
    endtask

    initial begin
        int e, d, r0, len, mode;

        // 1: reset then lock sampled on the 10th edge after reset
        drv_rst_n = 0; drv_locked = 0;
        tick();
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        r0 = cyc;
        drv_rst_n = 1;
        repeat (9) tick();
        drv_locked = 1;
        run_until_release(40, e);
        check("t1_release_edge", e, r0 + 10 + 2 + ST);
        check("t1_retry", retry_cnt, 0);

        // 2: no lock at all -> FAIL after three attempts, and it stays there
        drv_rst_n = 0; drv_locked = 0;
        tick();
        drv_rst_n = 1;
        repeat (3 * (RP + TO)) tick();
        check("t2_lock_fail", lock_fail, 1);
        check("t2_retry", retry_cnt, MR);
        repeat (100) tick();
        check("t2_hold_fail", lock_fail, 1);
        check("t2_hold_pll_rst", pll_rst, 1);
        check("t2_hold_sys_rst_n", sys_rst_n, 0);

        // 5: force_relock out of FAIL
        drv_force = 1;
        tick();
        drv_force = 0;
        check("t5_lock_fail", lock_fail, 0);
        check("t5_retry", retry_cnt, 0);
        check("t5_pll_rst", pll_rst, 1);
        drv_locked = 1;
        run_until_release(60, e);
        check("t5_ready", pll_ready, 1);

        // 3: one-cycle lock glitch at cnt=5 in STABLE restarts the window
        drv_force = 1;
        tick();
        drv_force = 0;
        wait_phase(P_STAB, 40);
        repeat (5) tick();
        drv_locked = 0;
        d = cyc + 1;
        tick();
        drv_locked = 1;
        run_until_release(40, e);
        check("t3_release_edge", e, d + 3 + ST);

        // 4: lock loss in RUN
        drv_locked = 0;
        d = cyc + 1;
        while (sys_rst_n === 1'b1 && cyc < d + 10) tick();
        check("t4_loss_edge", cyc, d + 2);
        check("t4_loss_cnt", loss_cnt, 1);
        repeat (RP - 1) tick();
        check("t4_pulse_high", pll_rst, 1);
        tick();
        check("t4_pulse_end", pll_rst, 0);
        for (int i = 0; i < 300; i++) begin
            drv_locked = 1;
            run_until_release(60, e);
            drv_locked = 0;
            repeat (3) tick();
        end
        check("t4_loss_sat", loss_cnt, 255);

        // 6: rst_n in RUN and in STABLE
        drv_locked = 1;
        run_until_release(60, e);
        drv_rst_n = 0;
        tick();
        check("t6_run_sys_rst_n", sys_rst_n, 0);
        check("t6_run_loss", loss_cnt, 0);
        drv_rst_n = 1;
        wait_phase(P_STAB, 40);
        repeat (2) tick();
        drv_rst_n = 0;
        tick();
        check("t6_stab_pll_rst", pll_rst, 1);
        drv_rst_n = 1;
        run_until_release(60, e);

        // random traffic
        for (int s = 0; s < 60; s++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 120);
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0: drv_locked = 1;
                    1: drv_locked = 0;
                    2: drv_locked = 1'($urandom_range(0, 1));
                    default: drv_locked = ($urandom_range(0, 15) != 0);
                endcase
                drv_force = ($urandom_range(0, 199) == 0);
                drv_rst_n = ($urandom_range(0, 499) != 0);
                tick();
            end
        end
        drv_force = 0;
        drv_rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
